// File: rtl/mul_round_pack_stage_if.sv
// Handshake bundle for the FPU_MUL round/pack stage.
// Upstream operand, downstream result and flags share one interface.
interface mul_round_pack_stage_if #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 24
);
    logic                         i_valid;
    logic                         o_ready;
    logic                         i_sign;
    logic [SIZE_EXP+1:0]          i_exp_sum;
    logic [2*SIZE_MAN-1:0]        i_man_prod;
    logic [1:0]                   i_sel_exp;
    logic [1:0]                   i_sel_man;
    logic                         o_valid;
    logic                         i_ready;
    logic [SIZE_EXP+SIZE_MAN-1:0] o_result;
    logic                         o_flag_ovf;
    logic                         o_flag_unf;
    logic                         o_flag_nan;
    logic                         o_flag_inexact;

    modport slave (
        input  i_valid,
        input  i_sign,
        input  i_exp_sum,
        input  i_man_prod,
        input  i_sel_exp,
        input  i_sel_man,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_result,
        output o_flag_ovf,
        output o_flag_unf,
        output o_flag_nan,
        output o_flag_inexact
    );

    modport master (
        output i_valid,
        output i_sign,
        output i_exp_sum,
        output i_man_prod,
        output i_sel_exp,
        output i_sel_man,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_result,
        input  o_flag_ovf,
        input  o_flag_unf,
        input  o_flag_nan,
        input  o_flag_inexact
    );
endinterface

// File: rtl/mul_round_pack_stage.sv
// FPU_MUL normalize, round-to-nearest-even, saturate and pack.
// Two register stages with a bubble-free valid/ready pipeline.
module mul_round_pack_stage #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 24,
    parameter int BIAS     = 127
) (
    input logic                  i_clk,
    input logic                  i_rst,
    mul_round_pack_stage_if.slave bus
);
    localparam int N  = SIZE_MAN;
    localparam int EI = SIZE_EXP + 3;
    localparam int RW = SIZE_EXP + SIZE_MAN;
    localparam logic signed [EI-1:0] EMAX = EI'((1 << SIZE_EXP) - 1);

    if (BIAS != (1 << (SIZE_EXP - 1)) - 1) begin : g_bias_check
        $error("BIAS does not match SIZE_EXP");
    end

    logic adv1;
    logic adv2;

    logic                 s1_valid;
    logic                 s1_sign;
    logic [1:0]           s1_sel_exp;
    logic [1:0]           s1_sel_man;
    logic signed [EI-1:0] s1_exp;
    logic [N-2:0]         s1_frac;
    logic                 s1_inexact;

    logic          s2_valid;
    logic [RW-1:0] s2_result;
    logic          s2_ovf;
    logic          s2_unf;
    logic          s2_nan;
    logic          s2_inexact;

    logic [2*N-1:0]       prod;
    logic                 hi;
    logic [N-1:0]         m_raw;
    logic                 g;
    logic                 s;
    logic                 up;
    logic                 carry;
    logic signed [EI-1:0] e_raw;
    logic signed [EI-1:0] e_nxt;
    logic [N-2:0]         frac_nxt;
    logic                 inexact_nxt;

    logic                ovf_c;
    logic                unf_c;
    logic                special;
    logic [SIZE_EXP-1:0] comp_exp;
    logic [N-2:0]        comp_frac;
    logic                comp_inexact;
    logic [SIZE_EXP-1:0] res_exp;
    logic [N-2:0]        res_frac;
    logic                res_sign;
    logic [RW-1:0]       res_word;
    logic                res_ovf;
    logic                res_unf;
    logic                res_nan;
    logic                res_inexact;

    assign prod = bus.i_man_prod;

    // Pipeline advance: a stage moves when empty or when its successor moves.
    assign adv2 = ~s2_valid | bus.i_ready;
    assign adv1 = ~s1_valid | adv2;

    assign bus.o_ready        = adv1;
    assign bus.o_valid        = s2_valid;
    assign bus.o_result       = s2_result;
    assign bus.o_flag_ovf     = s2_ovf;
    assign bus.o_flag_unf     = s2_unf;
    assign bus.o_flag_nan     = s2_nan;
    assign bus.o_flag_inexact = s2_inexact;

    // Normalize the product by one position and round to nearest-even.
    always_comb begin
        hi = prod[2*N-1];
        if (hi) begin
            m_raw = prod[2*N-1:N];
            g     = prod[N-1];
            s     = |prod[N-2:0];
        end else begin
            m_raw = prod[2*N-2:N-1];
            g     = prod[N-2];
            s     = |prod[N-3:0];
        end
        e_raw = {bus.i_exp_sum[SIZE_EXP+1], bus.i_exp_sum} + EI'(hi);
        up    = g & (s | m_raw[0]);
        // All-ones mantissa rounding up wraps the fraction to zero
        // and bumps the exponent; the hidden bit stays set.
        carry       = up & (&m_raw);
        frac_nxt    = m_raw[N-2:0] + (N-1)'(up);
        e_nxt       = e_raw + EI'(carry);
        inexact_nxt = g | s;
    end

    // Stage 1 registers: rounded mantissa, exponent and classifier codes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_sel_exp <= 2'b00;
            s1_sel_man <= 2'b00;
            s1_exp     <= '0;
            s1_frac    <= '0;
            s1_inexact <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_sign    <= bus.i_sign;
                s1_sel_exp <= bus.i_sel_exp;
                s1_sel_man <= bus.i_sel_man;
                s1_exp     <= e_nxt;
                s1_frac    <= frac_nxt;
                s1_inexact <= inexact_nxt;
            end
        end
    end

    // Saturate the computed value, then apply the classifier override.
    always_comb begin
        ovf_c   = ~s1_exp[EI-1] & (s1_exp >= EMAX);
        unf_c   = s1_exp[EI-1] | (s1_exp == '0);
        special = |{s1_sel_exp, s1_sel_man};

        comp_exp     = s1_exp[SIZE_EXP-1:0];
        comp_frac    = s1_frac;
        comp_inexact = s1_inexact;
        if (ovf_c) begin
            comp_exp     = '1;
            comp_frac    = '0;
            comp_inexact = 1'b1;
        end else if (unf_c) begin
            comp_exp  = '0;
            comp_frac = '0;
        end

        res_exp = comp_exp;
        unique case (s1_sel_exp)
            2'b00:   res_exp = comp_exp;
            2'b10:   res_exp = '0;
            default: res_exp = '1;
        endcase

        res_frac = comp_frac;
        res_sign = s1_sign;
        unique case (s1_sel_man)
            2'b00: res_frac = comp_frac;
            2'b11: begin
                res_frac = {1'b1, {(N-2){1'b0}}};
                res_sign = 1'b0;
            end
            default: res_frac = '0;
        endcase

        res_word    = {res_sign, res_exp, res_frac};
        res_ovf     = ~special & ovf_c;
        res_unf     = ~special & ~ovf_c & unf_c;
        res_inexact = ~special & comp_inexact;
        res_nan     = (s1_sel_man == 2'b11);
    end

    // Stage 2 registers drive the outputs and hold them while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_ovf     <= 1'b0;
            s2_unf     <= 1'b0;
            s2_nan     <= 1'b0;
            s2_inexact <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result  <= res_word;
                s2_ovf     <= res_ovf;
                s2_unf     <= res_unf;
                s2_nan     <= res_nan;
                s2_inexact <= res_inexact;
            end
        end
    end
endmodule

// File: doc/mul_round_pack_stage.md
Name: mul_round_pack_stage

Overview:
- Downstream neighbour of the multiplier special-case classifier in the FPU_MUL datapath.
- Takes the raw mantissa product, exponent sum, result sign and the classifier's exponent/mantissa select codes.
- Normalizes the product and rounds it to nearest-even, then applies overflow/underflow saturation and the special-case override, and packs the IEEE-754 word.
- Two-stage pipeline with a valid/ready handshake on both sides. Feeds the FFT butterfly adders.

Parameters:
- SIZE_EXP, 8, exponent field width.
- SIZE_MAN, 24, mantissa width including the hidden bit. The packed fraction is SIZE_MAN-1 bits.
- BIAS, 127, exponent bias. Used only for documentation and checks; i_exp_sum is already unbiased-corrected.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  upstream operand valid.
- o_ready  out  1  stage can accept an operand this cycle.
- i_sign  in  1  result sign (sign_a ^ sign_b).
- i_exp_sum  in  SIZE_EXP+2  signed two's-complement value exp_a+exp_b-BIAS.
- i_man_prod  in  2*SIZE_MAN  unsigned product of the two hidden-bit mantissas.
- i_sel_exp  in  2  classifier exponent select.
- i_sel_man  in  2  classifier mantissa select.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  1+SIZE_EXP+SIZE_MAN-1  packed {sign, exp, frac}.
- o_flag_ovf  out  1  overflow to infinity.
- o_flag_unf  out  1  underflow, flushed to zero.
- o_flag_nan  out  1  result is NaN.
- o_flag_inexact  out  1  rounding discarded nonzero bits.

Behaviour:
- Notation: N = SIZE_MAN, EMAX = 2^SIZE_EXP-1.
- Reset: s1_valid=0, s2_valid=0. o_valid, o_result and all flags are 0. o_ready=1 one cycle after reset deasserts.
- Handshake and flow:
  - adv2 = ~s2_valid | i_ready.
  - adv1 = ~s1_valid | adv2.
  - o_ready = adv1. This is combinational with no bubble, so throughput is 1 result/cycle.
  - Input accepted when i_valid & o_ready. The result appears with o_valid exactly 2 cycles later when i_ready is held high.
  - While o_valid & ~i_ready, o_result and the flags are held stable. Stage 1 holds only if it is valid.
  - Stage registers load only on advance. No data is dropped or duplicated under any i_ready pattern.
- Stage 1 (normalize + round):
  - If i_man_prod[2N-1]=1: m = prod[2N-1:N], g = prod[N-1], s = |prod[N-2:0], e = i_exp_sum+1.
  - Else: m = prod[2N-2:N-1], g = prod[N-2], s = |prod[N-3:0], e = i_exp_sum.
  - RNE: round up iff g & (s | m[0]).
  - If the round-up carries out (m all ones): m = 1 followed by zeros, e = e+1.
  - inexact = g | s.
  - i_sign, sel codes and the rounding results are registered into stage 1.
- Stage 2 (saturate + override + pack):
  - Computed path, taken only when sel_exp=00 and sel_man=00:
    - e >= EMAX: result is ±inf, ovf=1, inexact=1.
    - e <= 0: result is ±0, unf=1. No subnormals are produced.
    - Otherwise: {sign, e[SIZE_EXP-1:0], m[N-2:0]}.
  - sel_exp override: 00 computed, 01 all-ones, 10 all-zeros, 11 all-ones.
  - sel_man override: 00 computed, 01 zero, 10 zero, 11 quiet NaN fraction (MSB=1, rest 0).
  - sel_man=11 forces sign=0 and sets nan=1.
  - When any sel is nonzero, ovf, unf and inexact are 0.
- Illegal pair (sel_exp=00 with sel_man≠00): the exponent is computed and the fraction is overridden. Not produced by the classifier; the bench asserts it never occurs.
- Reset mid-operation clears both valids immediately (asynchronously). In-flight results are discarded and not replayed.

Test Plan:
- 1.5×1.5: i_man_prod=48'h900000000000, i_exp_sum=127, sels=00 -> o_result=32'h40100000 two cycles later, all flags 0.
- RNE tie, even: prod=48'h400000400000, exp 127 -> 32'h3F800000, inexact=1.
- RNE tie, odd: prod=48'h400000C00000, exp 127 -> 32'h3F800002, inexact=1.
- Overflow: i_exp_sum=255, prod=48'h400000000000, sign=1 -> 32'hFF800000, ovf=1.
- Underflow: i_exp_sum=0, same prod, sign=0 -> 32'h00000000, unf=1.
- NaN override: sel_exp=11, sel_man=11, i_sign=1 -> 32'h7FC00000, nan=1.
- Infinity override: sel_exp=01, sel_man=01, i_sign=1 -> 32'hFF800000, ovf=0.
- Backpressure: stream 8 back-to-back operands while i_ready toggles 1,0,0,1,... -> all 8 results delivered in order with no loss or duplication. o_ready=0 only when both stages are full and i_ready=0. Outputs stay stable while stalled.
- Reset mid-stream: assert i_rst with both stages valid -> o_valid drops in the same cycle. After release, o_ready=1, and the first new operand yields its result after 2 cycles.
